// File: rtl/hv_accum_stream.sv
// hv_accum_stream: per-dimension saturating majority accumulator that snapshots and streams its sign vector
module hv_accum_stream #(
  parameter int DIM     = 1024,
  parameter int CORENUM = 16,
  parameter int CNT_W   = 26,
  parameter int OUT_W   = 64,
  parameter bit TIE_BIT = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CORENUM*DIM-1:0] core_result,
  input  logic [CORENUM-1:0]     store,
  input  logic                   clear,
  input  logic                   last,
  output logic [OUT_W-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   busy,
  output logic                   sat_flag,
  output logic                   last_drop
);
  localparam int NB = DIM / OUT_W;
  localparam int IW = NB > 1 ? $clog2(NB) : 1;
  localparam int DW = $clog2(CORENUM) + 2;
  localparam int SW = (CNT_W > DW ? CNT_W : DW) + 1;
  localparam logic signed [CNT_W-1:0] CMAX = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic signed [CNT_W-1:0] CMIN = -CMAX;
  typedef enum logic [1:0] {IDLE, SNAP, STREAM} state_t;
  state_t r_state, w_state_nxt;
  logic signed [CNT_W-1:0] r_cnt [DIM];
  logic signed [CNT_W-1:0] w_cnt_nxt [DIM];
  logic [DIM-1:0] w_clamp, w_sign, r_shadow;
  logic [IW-1:0] r_idx;
  logic w_fire, w_beat_last;
  for (genvar d = 0; d < DIM; d++) begin : g_dim
    logic signed [DW-1:0] w_delta;
    logic signed [SW-1:0] w_sum;
    // net vote of the enabled lanes for this dimension
    always_comb begin
      w_delta = '0;
      for (int c = 0; c < CORENUM; c++)
        w_delta = store[c] ? (core_result[c*DIM+d] ? w_delta + DW'(1) : w_delta - DW'(1)) : w_delta;
    end
    assign w_sum = (clear ? SW'(0) : SW'(r_cnt[d])) + SW'(w_delta);
    assign w_clamp[d] = (w_sum > SW'(CMAX)) || (w_sum < SW'(CMIN));
    assign w_cnt_nxt[d] = w_sum > SW'(CMAX) ? CMAX : w_sum < SW'(CMIN) ? CMIN : w_sum[CNT_W-1:0];
    assign w_sign[d] = r_cnt[d] == '0 ? TIE_BIT : ~r_cnt[d][CNT_W-1];
  end
  // counters accumulate every cycle, independent of the streaming state
  always_ff @(posedge clk) begin
    if (rst) r_cnt <= '{default: '0};
    else r_cnt <= w_cnt_nxt;
  end
  // state register
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_state_nxt;
  // next state and beat presentation; data is held by r_idx until the handshake
  always_comb begin
    w_state_nxt = r_state;
    out_valid   = r_state == STREAM;
    busy        = r_state != IDLE;
    w_beat_last = r_idx == IW'(NB - 1);
    w_fire      = out_valid & out_ready;
    out_last    = out_valid & w_beat_last;
    out_data    = out_valid ? r_shadow[r_idx*OUT_W +: OUT_W] : '0;
    w_state_nxt = r_state == IDLE ? (last ? SNAP : IDLE) :
                  r_state == SNAP ? STREAM :
                  (w_fire && w_beat_last) ? IDLE : STREAM;
  end
  // shadow capture, beat index and sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow  <= '0;
      r_idx     <= '0;
      sat_flag  <= 1'b0;
      last_drop <= 1'b0;
    end else begin
      r_shadow  <= r_state == SNAP ? w_sign : r_shadow;
      r_idx     <= r_state == SNAP ? '0 : w_fire ? r_idx + 1'b1 : r_idx;
      sat_flag  <= sat_flag | (|w_clamp);
      last_drop <= last_drop | (last & busy);
    end
  end
endmodule
